raster_engine: RTL

- Parameterised monochrome rasteriser: holds a 2**X_BITS by 2**Y_BITS one-bit frame buffer.
- Executes one draw command per valid/ready handshake: CLEAR, POINT, filled RECT or Bresenham LINE.
- When requested, streams the whole frame row-major as OUT_W-pixel beats under valid/ready backpressure.
- Sits between the command decoder and the display/serialiser path; successor to the fixed 8x8 point-only processor.

---
 rtl/raster_engine_if.sv | 34 +++
 rtl/raster_engine.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/raster_engine_if.sv
// Command and pixel-stream bundle for raster_engine.
// The master issues draw commands and sinks pixel beats; the slave is the engine.
interface raster_engine_if #(
  parameter int unsigned X_BITS = 3,
  parameter int unsigned Y_BITS = 3,
  parameter int unsigned OUT_W  = 4
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic              cmd_present;
  logic [X_BITS-1:0] x1;
  logic [Y_BITS-1:0] y1;
  logic [X_BITS-1:0] x2;
  logic [Y_BITS-1:0] y2;
  logic [X_BITS-1:0] rect_w;
  logic [Y_BITS-1:0] rect_h;
  logic              pix_valid;
  logic              pix_ready;
  logic [OUT_W-1:0]  pix_data;
  logic              frame_start;
  logic              frame_end;
  logic              busy;

  modport master (
    output cmd_valid, cmd_op, cmd_present, x1, y1, x2, y2, rect_w, rect_h, pix_ready,
    input  cmd_ready, pix_valid, pix_data, frame_start, frame_end, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_present, x1, y1, x2, y2, rect_w, rect_h, pix_ready,
    output cmd_ready, pix_valid, pix_data, frame_start, frame_end, busy
  );
endinterface

// File: rtl/raster_engine.sv
// Monochrome rasteriser: one-bit frame buffer with CLEAR/POINT/RECT/LINE draw commands
// and an optional row-major frame stream of OUT_W-pixel beats after each command.
module raster_engine #(
  parameter int unsigned X_BITS = 3,
  parameter int unsigned Y_BITS = 3,
  parameter int unsigned OUT_W  = 4
) (
  input logic            clk,
  input logic            rst_n,
  raster_engine_if.slave bus
);
  localparam int unsigned W         = 1 << X_BITS;
  localparam int unsigned H         = 1 << Y_BITS;
  localparam int unsigned B         = W * H / OUT_W;
  localparam int unsigned BEAT_BITS = (B > 1) ? $clog2(B) : 1;
  localparam int unsigned PIX_BITS  = X_BITS + Y_BITS;
  localparam int unsigned OUT_LOG   = $clog2(OUT_W);
  localparam int unsigned E_BITS    = X_BITS + Y_BITS + 2;

  typedef enum logic [2:0] {StIdle, StClr, StPt, StRect, StLine, StStream} state_e;

  state_e                     state_q, state_d;
  logic [W-1:0]               fb_q [H];
  logic [W-1:0]               fb_d [H];
  logic [X_BITS-1:0]          x1_q, x1_d, x2_q, x2_d, xe_q, xe_d, cx_q, cx_d;
  logic [Y_BITS-1:0]          y1_q, y1_d, y2_q, y2_d, ye_q, ye_d, cy_q, cy_d;
  logic                       present_q, present_d, sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
  logic signed [E_BITS-1:0]   err_q, err_d, dx_q, dx_d, dy_q, dy_d, e2;
  logic [BEAT_BITS-1:0]       beat_q, beat_d;
  logic [X_BITS:0]            xsum;
  logic [Y_BITS:0]            ysum;
  logic [X_BITS-1:0]          adx;
  logic [Y_BITS-1:0]          ady;
  logic [PIX_BITS-1:0]        pix_base;
  logic                       done;

  // Command-time geometry: clipped rect corner and absolute line deltas.
  always_comb begin
    xsum = {1'b0, bus.x1} + {1'b0, bus.rect_w};
    ysum = {1'b0, bus.y1} + {1'b0, bus.rect_h};
    adx  = (bus.x2 >= bus.x1) ? bus.x2 - bus.x1 : bus.x1 - bus.x2;
    ady  = (bus.y2 >= bus.y1) ? bus.y2 - bus.y1 : bus.y1 - bus.y2;
  end

  always_comb begin
    state_d   = state_q;
    fb_d      = fb_q;
    x1_d      = x1_q;
    x2_d      = x2_q;
    xe_d      = xe_q;
    cx_d      = cx_q;
    y1_d      = y1_q;
    y2_d      = y2_q;
    ye_d      = ye_q;
    cy_d      = cy_q;
    present_d = present_q;
    sx_neg_d  = sx_neg_q;
    sy_neg_d  = sy_neg_q;
    err_d     = err_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    beat_d    = beat_q;
    e2        = err_q <<< 1;
    done      = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus.cmd_valid) begin
          x1_d      = bus.x1;
          y1_d      = bus.y1;
          x2_d      = bus.x2;
          y2_d      = bus.y2;
          xe_d      = xsum[X_BITS] ? '1 : xsum[X_BITS-1:0];
          ye_d      = ysum[Y_BITS] ? '1 : ysum[Y_BITS-1:0];
          present_d = bus.cmd_present;
          sx_neg_d  = bus.x2 < bus.x1;
          sy_neg_d  = bus.y2 < bus.y1;
          dx_d      = E_BITS'(adx);
          dy_d      = -E_BITS'(ady);
          err_d     = E_BITS'(adx) - E_BITS'(ady);
          cx_d      = bus.x1;
          cy_d      = bus.y1;
          unique case (bus.cmd_op)
            2'b00: begin
              state_d = StClr;
              cy_d    = '0;
            end
            2'b01:   state_d = StPt;
            2'b10:   state_d = StRect;
            default: state_d = StLine;
          endcase
        end
      end
      StClr: begin
        fb_d[cy_q] = '0;
        if (cy_q == '1) done = 1'b1;
        else            cy_d = cy_q + 1'b1;
      end
      StPt: begin
        fb_d[y1_q][x1_q] = 1'b1;
        done             = 1'b1;
      end
      StRect: begin
        fb_d[cy_q][cx_q] = 1'b1;
        if (cx_q == xe_q) begin
          cx_d = x1_q;
          if (cy_q == ye_q) done = 1'b1;
          else              cy_d = cy_q + 1'b1;
        end else begin
          cx_d = cx_q + 1'b1;
        end
      end
      StLine: begin
        fb_d[cy_q][cx_q] = 1'b1;
        if (cx_q == x2_q && cy_q == y2_q) begin
          done = 1'b1;
        end else begin
          if (e2 >= dy_q) begin
            err_d = err_d + dy_q;
            cx_d  = sx_neg_q ? cx_q - 1'b1 : cx_q + 1'b1;
          end
          if (e2 <= dx_q) begin
            err_d = err_d + dx_q;
            cy_d  = sy_neg_q ? cy_q - 1'b1 : cy_q + 1'b1;
          end
        end
      end
      StStream: begin
        if (bus.pix_ready) begin
          if (beat_q == BEAT_BITS'(B - 1)) state_d = StIdle;
          else                             beat_d  = beat_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (done) begin
      state_d = present_q ? StStream : StIdle;
      beat_d  = '0;
    end
  end

  // Outputs depend only on state and beat, so they hold steady while stalled.
  always_comb begin
    pix_base        = PIX_BITS'(beat_q) << OUT_LOG;
    bus.cmd_ready   = (state_q == StIdle);
    bus.busy        = (state_q != StIdle);
    bus.pix_valid   = (state_q == StStream);
    bus.pix_data    = '0;
    bus.frame_start = 1'b0;
    bus.frame_end   = 1'b0;
    if (state_q == StStream) begin
      bus.pix_data    = fb_q[pix_base[PIX_BITS-1 -: Y_BITS]][pix_base[X_BITS-1:0] +: OUT_W];
      bus.frame_start = (beat_q == '0);
      bus.frame_end   = (beat_q == BEAT_BITS'(B - 1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      for (int r = 0; r < int'(H); r++) fb_q[r] <= '0;
      x1_q      <= '0;
      x2_q      <= '0;
      xe_q      <= '0;
      cx_q      <= '0;
      y1_q      <= '0;
      y2_q      <= '0;
      ye_q      <= '0;
      cy_q      <= '0;
      present_q <= 1'b0;
      sx_neg_q  <= 1'b0;
      sy_neg_q  <= 1'b0;
      err_q     <= '0;
      dx_q      <= '0;
      dy_q      <= '0;
      beat_q    <= '0;
    end else begin
      state_q   <= state_d;
      fb_q      <= fb_d;
      x1_q      <= x1_d;
      x2_q      <= x2_d;
      xe_q      <= xe_d;
      cx_q      <= cx_d;
      y1_q      <= y1_d;
      y2_q      <= y2_d;
      ye_q      <= ye_d;
      cy_q      <= cy_d;
      present_q <= present_d;
      sx_neg_q  <= sx_neg_d;
      sy_neg_q  <= sy_neg_d;
      err_q     <= err_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      beat_q    <= beat_d;
    end
  end
endmodule
